// File: rtl/demux_1to2_buffered_pkg.sv
// Shared constants for the 1-to-2 buffered demux: datapath width and the
// path encodings that callers drive onto `select`.
package demux_1to2_buffered_pkg;

    localparam int   DATA_W   = 32;

    // Path encodings for `select`: write-back goes to out1, memory to out2.
    localparam logic PATH_WB  = 1'b0;
    localparam logic PATH_MEM = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO, DEPTH entries (power of two), one-cycle push-to-head latency.
// Push is ignored when full and pop is ignored when empty, so count stays within 0..DEPTH.
module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so the natural roll-over is the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_1to2_buffered.sv
// Steers one valid/ready word stream into one of two per-path FIFOs by `select`.
// One-cycle latency to the output head; in_ready depends only on select and the chosen FIFO's full flag.
module demux_1to2_buffered
    import demux_1to2_buffered_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    out1_count,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [CW-1:0]    out2_count
);

    logic full1, full2;
    logic empty1, empty2;
    logic sel_full;
    logic push_en;

    // No pop-through: a full FIFO refuses input even while it is being drained.
    assign sel_full = (select == PATH_MEM) ? full2 : full1;
    assign in_ready = rst_n && !sel_full;
    assign push_en  = in_valid && in_ready;

    assign out1_valid = !empty1;
    assign out2_valid = !empty2;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_en && (select == PATH_WB)),
        .push_dat_i (in_data),
        .pop_i      (out1_ready),
        .head_dat_o (out1_data),
        .count_o    (out1_count),
        .full_o     (full1),
        .empty_o    (empty1)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_en && (select == PATH_MEM)),
        .push_dat_i (in_data),
        .pop_i      (out2_ready),
        .head_dat_o (out2_data),
        .count_o    (out2_count),
        .full_o     (full2),
        .empty_o    (empty2)
    );

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Bench for demux_1to2_buffered: a per-path scoreboard checked every cycle, a vector table
// for steering/backpressure/full-with-pop, and hand sequences for streaming and mid-run reset.
module tb_demux_1to2_buffered;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        select;
    logic        out1_valid, out1_ready;
    logic [31:0] out1_data;
    logic [1:0]  out1_count;
    logic        out2_valid, out2_ready;
    logic [31:0] out2_data;
    logic [1:0]  out2_count;

    int total = 0;
    int bad   = 0;
    bit mon_en = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    demux_1to2_buffered #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_count (out1_count),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .out2_count (out2_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: checks state at the negedge, then commits the handshakes of the coming posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            automatic int  s1 = q1.size();
            automatic int  s2 = q2.size();
            automatic logic exp_rdy = rst_n && ((select ? s2 : s1) < DEPTH);
            chk("mon_in_ready",   {31'b0, in_ready},   {31'b0, exp_rdy});
            chk("mon_out1_valid", {31'b0, out1_valid}, {31'b0, s1 != 0});
            chk("mon_out2_valid", {31'b0, out2_valid}, {31'b0, s2 != 0});
            chk("mon_out1_count", {30'b0, out1_count}, s1);
            chk("mon_out2_count", {30'b0, out2_count}, s2);
            if (s1 != 0) chk("mon_out1_data", out1_data, q1[0]);
            if (s2 != 0) chk("mon_out2_data", out2_data, q2[0]);
            if (rst_n) begin
                if (s1 != 0 && out1_ready) void'(q1.pop_front());
                if (s2 != 0 && out2_ready) void'(q2.pop_front());
                if (in_valid && exp_rdy) begin
                    if (select) q2.push_back(in_data);
                    else        q1.push_back(in_data);
                end
            end
        end
    end

    typedef struct {
        logic        vld;
        logic        sel;
        logic [31:0] dat;
        logic        r1;
        logic        r2;
        logic        exp_rdy;
        int          exp_c1;
        int          exp_c2;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input logic vld, input logic sel, input logic [31:0] dat,
                         input logic r1, input logic r2);
        in_valid   = vld;
        select     = sel;
        in_data    = dat;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    initial begin
        // steering with both consumers ready
        vecs[0]  = '{1'b1, 1'b0, 32'd5, 1'b1, 1'b1, 1'b1, 1, 0};
        vecs[1]  = '{1'b1, 1'b1, 32'd9, 1'b1, 1'b1, 1'b1, 0, 1};
        vecs[2]  = '{1'b1, 1'b0, 32'd7, 1'b1, 1'b1, 1'b1, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 0, 0};
        // out1 stalled: fills at 2, third word refused, other path still flows
        vecs[4]  = '{1'b1, 1'b0, 32'd1, 1'b0, 1'b1, 1'b1, 1, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'd2, 1'b0, 1'b1, 1'b1, 2, 0};
        vecs[6]  = '{1'b1, 1'b0, 32'd3, 1'b0, 1'b1, 1'b0, 2, 0};
        vecs[7]  = '{1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 2, 1};
        vecs[8]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 2, 0};
        // full with simultaneous pop: refused that cycle, accepted the next
        vecs[9]  = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 1'b0, 1, 0};
        vecs[10] = '{1'b1, 1'b0, 32'd3, 1'b1, 1'b1, 1'b1, 1, 0};
        vecs[11] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 0, 0};

        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // reset asserted mid-cycle clears outputs at once
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",   {31'b0, in_ready},   32'd0);
        chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
        chk("rst_out1_count", {30'b0, out1_count}, 32'd0);
        chk("rst_out2_count", {30'b0, out2_count}, 32'd0);
        chk("rst_out1_data",  out1_data,           32'd0);
        mon_en = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        #1 chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vld, vecs[i].sel, vecs[i].dat, vecs[i].r1, vecs[i].r2);
            #3 chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_count1", i), {30'b0, out1_count}, vecs[i].exp_c1);
            chk($sformatf("vec%0d_count2", i), {30'b0, out2_count}, vecs[i].exp_c2);
        end

        // streaming on out2: push and pop every cycle keeps count at 1, pointers wrap
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 32'd10 + k, 1'b1, 1'b1);
            #3 chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("stream%0d_count2", k), {30'b0, out2_count}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("stream_drain_count2", {30'b0, out2_count}, 32'd0);

        // reset with words buffered on both paths
        drive(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b1, 32'hB2, 1'b0, 1'b0);
        @(posedge clk); #1 drive(1'b1, 1'b0, 32'hA3, 1'b0, 1'b0);
        @(posedge clk); #1 drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("pre_rst_count1", {30'b0, out1_count}, 32'd2);
        chk("pre_rst_count2", {30'b0, out2_count}, 32'd1);
        #1 rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk("midrst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("midrst_out2_valid", {31'b0, out2_valid}, 32'd0);
        chk("midrst_count1",     {30'b0, out1_count}, 32'd0);
        chk("midrst_count2",     {30'b0, out2_count}, 32'd0);
        chk("midrst_out2_data",  out2_data,           32'd0);
        chk("midrst_in_ready",   {31'b0, in_ready},   32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        @(posedge clk); #1 drive(1'b1, 1'b0, 32'h55, 1'b1, 1'b1);
        @(posedge clk); #1 drive(1'b1, 1'b1, 32'h66, 1'b1, 1'b1);
        @(posedge clk); #1 drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_count1", {30'b0, out1_count}, 32'd0);
        chk("post_rst_count2", {30'b0, out2_count}, 32'd0);
        chk("post_rst_sb1_empty", q1.size(), 32'd0);
        chk("post_rst_sb2_empty", q2.size(), 32'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
